// File: rtl/dual_serial_tx_pkg.sv
// Shared types and constants for the dual-lane serial transmitter.
// Optional parity frame bit is enabled by defining DUAL_SERIAL_TX_PARITY_EN.
package dual_serial_pkg;

  localparam int unsigned DEF_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Even parity (XOR reduction) of a word up to 32 bits, zero-extended.
  function automatic logic word_parity(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/dual_serial_tx_if.sv
// Load handshake and two-lane serial output bundle of dual_serial_tx.
// The slave modport is the transmitter; the master modport is its stimulus source.
interface dual_serial_tx_if
  import dual_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             out_1;
  logic             out_2;
  logic             valid_o;
  logic             last_o;
  logic             done_o;

  modport master (
    output start_i, a_i, b_i,
    input  ready_o, out_1, out_2, valid_o, last_o, done_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output ready_o, out_1, out_2, valid_o, last_o, done_o
  );

endinterface

// File: rtl/dual_serial_tx_piso_lane.sv
// One serial lane: WIDTH-bit load/shift-left register presenting its MSB,
// plus a running XOR of shifted-out bits when DUAL_SERIAL_TX_PARITY_EN is defined.
module piso_lane #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
`ifdef DUAL_SERIAL_TX_PARITY_EN
  output logic             par,
`endif
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef DUAL_SERIAL_TX_PARITY_EN
  // Accumulated over the bits actually sent, so it equals the word's parity
  // exactly when the last data bit has left the register.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      par <= 1'b0;
    end else if (shift) begin
      par <= par ^ sreg[WIDTH-1];
    end
  end
`endif

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/dual_serial_tx.sv
// Dual-lane MSB-first parallel-to-serial transmitter with load handshake.
// Define DUAL_SERIAL_TX_PARITY_EN to append a per-lane even-parity bit to each frame.
module dual_serial_tx
  import dual_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  dual_serial_tx_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ready_r;
  logic             valid_r;
  logic             last_r;
  logic             done_r;
  logic             load;
  logic             shift;
  logic             msb_a;
  logic             msb_b;
`ifdef DUAL_SERIAL_TX_PARITY_EN
  logic             par_a;
  logic             par_b;
`endif

  assign load  = (state == ST_IDLE) && bus.start_i;
  assign shift = (state == ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            state   <= ST_SHIFT;
            cnt     <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
`ifdef DUAL_SERIAL_TX_PARITY_EN
            state   <= ST_PARITY;
            valid_r <= 1'b1;
            last_r  <= 1'b1;
`else
            state   <= ST_DONE;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
`ifndef DUAL_SERIAL_TX_PARITY_EN
            // last_o is registered, so it is raised one edge before the final bit.
            last_r <= (cnt == CNT_PENULT);
`endif
          end
        end
        ST_PARITY: begin
          state   <= ST_DONE;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  piso_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .data  (bus.a_i),
`ifdef DUAL_SERIAL_TX_PARITY_EN
    .par   (par_a),
`endif
    .msb   (msb_a)
  );

  piso_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .data  (bus.b_i),
`ifdef DUAL_SERIAL_TX_PARITY_EN
    .par   (par_b),
`endif
    .msb   (msb_b)
  );

  // Lane bits are gated by the registered valid flag, so idle outputs are 0
  // and no input reaches an output without passing a flop.
`ifdef DUAL_SERIAL_TX_PARITY_EN
  assign bus.out_1 = valid_r & ((state == ST_PARITY) ? par_a : msb_a);
  assign bus.out_2 = valid_r & ((state == ST_PARITY) ? par_b : msb_b);
`else
  assign bus.out_1 = valid_r & msb_a;
  assign bus.out_2 = valid_r & msb_b;
`endif

  assign bus.ready_o = ready_r;
  assign bus.valid_o = valid_r;
  assign bus.last_o  = last_r;
  assign bus.done_o  = done_r;

endmodule

// File: tb/tb_dual_serial_tx.sv
// Directed, table-driven bench for dual_serial_tx (WIDTH=6); parity checks
// are included when DUAL_SERIAL_TX_PARITY_EN is defined.
module tb_dual_serial_tx;
  import dual_serial_pkg::*;

  localparam int unsigned W = 6;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic         p1;
    logic         p2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dual_serial_tx_if #(.WIDTH(W)) bus ();

  dual_serial_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(bus.ready_o), 32'd1);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_valid0"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_out1_0"}, 32'(bus.out_1), 32'd0);
    chk({tag, "_out2_0"}, 32'(bus.out_2), 32'd0);
    chk({tag, "_last0"}, 32'(bus.last_o), 32'd0);
  endtask

  // One complete frame; inputs are scrambled after the accept edge to show
  // that the frame in flight is unaffected.
  task automatic run_frame(input vec_t v, input string tag);
    logic exp_last;
    wait_ready(tag);
    bus.start_i = 1'b1;
    bus.a_i = v.a;
    bus.b_i = v.b;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.a_i = ~v.a;
    bus.b_i = ~v.b;
    for (int k = 0; k < int'(W); k++) begin
`ifdef DUAL_SERIAL_TX_PARITY_EN
      exp_last = 1'b0;
`else
      exp_last = (k == int'(W) - 1);
`endif
      chk($sformatf("%s_valid_b%0d", tag, k), 32'(bus.valid_o), 32'd1);
      chk($sformatf("%s_out1_b%0d", tag, k), 32'(bus.out_1), 32'(v.e1[W-1-k]));
      chk($sformatf("%s_out2_b%0d", tag, k), 32'(bus.out_2), 32'(v.e2[W-1-k]));
      chk($sformatf("%s_last_b%0d", tag, k), 32'(bus.last_o), 32'(exp_last));
      chk($sformatf("%s_busy_b%0d", tag, k), 32'({bus.ready_o, bus.done_o}), 32'd0);
      @(negedge clk);
    end
`ifdef DUAL_SERIAL_TX_PARITY_EN
    chk({tag, "_par_valid"}, 32'(bus.valid_o), 32'd1);
    chk({tag, "_par_out1"}, 32'(bus.out_1), 32'(v.p1));
    chk({tag, "_par_out2"}, 32'(bus.out_2), 32'(v.p2));
    chk({tag, "_par_last"}, 32'(bus.last_o), 32'd1);
    chk({tag, "_par_ref1"}, 32'(word_parity(32'(v.a))), 32'(v.p1));
    @(negedge clk);
`endif
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_done_ready0"}, 32'(bus.ready_o), 32'd0);
    chk_idle_outs({tag, "_donecyc"});
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(bus.ready_o), 32'd1);
    chk({tag, "_done_1cyc"}, 32'(bus.done_o), 32'd0);
  endtask

  vec_t vecs[5];
  logic [W-1:0] seen1;
  logic [W-1:0] seen2;
  int unsigned  gap;
  int unsigned  vcount;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 6'b100100, b: 6'b100010, e1: 6'b100100, e2: 6'b100010, p1: 1'b0, p2: 1'b0};
    vecs[1] = '{a: 6'b111111, b: 6'b000000, e1: 6'b111111, e2: 6'b000000, p1: 1'b0, p2: 1'b0};
    vecs[2] = '{a: 6'b101010, b: 6'b010101, e1: 6'b101010, e2: 6'b010101, p1: 1'b1, p2: 1'b1};
    vecs[3] = '{a: 6'b100000, b: 6'b000001, e1: 6'b100000, e2: 6'b000001, p1: 1'b1, p2: 1'b1};
    vecs[4] = '{a: 6'b110011, b: 6'b011011, e1: 6'b110011, e2: 6'b011011, p1: 1'b0, p2: 1'b0};

    // Reset held with start high: nothing may start.
    bus.start_i = 1'b1;
    bus.a_i = 6'h3F;
    bus.b_i = 6'h3F;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_ready_%0d", i), 32'(bus.ready_o), 32'd1);
      chk($sformatf("rst_done_%0d", i), 32'(bus.done_o), 32'd0);
      chk_idle_outs($sformatf("rst_%0d", i));
    end
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk_idle_outs("post_rst");
    chk("post_rst_ready", 32'(bus.ready_o), 32'd1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Busy ignore: start with a=3F during a zero frame.
    wait_ready("busy");
    bus.start_i = 1'b1;
    bus.a_i = 6'h00;
    bus.b_i = 6'h00;
    @(negedge clk);
    bus.start_i = 1'b0;
    seen1 = '0;
    for (int k = 0; k < int'(W); k++) begin
      seen1[W-1-k] = bus.out_1;
      if (k == 2) begin
        bus.start_i = 1'b1;
        bus.a_i = 6'h3F;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk("busy_lane1_zero", 32'(seen1), 32'd0);
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid_o === 1'b1) vcount++;
      @(negedge clk);
    end
`ifdef DUAL_SERIAL_TX_PARITY_EN
    chk("busy_no_second_frame", 32'(vcount), 32'd1);
`else
    chk("busy_no_second_frame", 32'(vcount), 32'd0);
`endif

    // Back-to-back with start held high.
    wait_ready("b2b");
    bus.start_i = 1'b1;
    bus.a_i = 6'h2A;
    bus.b_i = 6'h15;
    @(negedge clk);
    bus.a_i = 6'h15;
    bus.b_i = 6'h2A;
    seen1 = '0;
    seen2 = '0;
    for (int k = 0; k < int'(W); k++) begin
      seen1[W-1-k] = bus.out_1;
      @(negedge clk);
    end
`ifdef DUAL_SERIAL_TX_PARITY_EN
    chk("b2b_f1_par", 32'(bus.out_1), 32'd1);
    @(negedge clk);
`endif
    gap = 0;
    while (bus.valid_o !== 1'b1 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("b2b_gap", 32'(gap), 32'd2);
    bus.start_i = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      seen2[W-1-k] = bus.out_1;
      @(negedge clk);
    end
    chk("b2b_frame1", 32'(seen1), 32'h2A);
    chk("b2b_frame2", 32'(seen2), 32'h15);

    // Mid-frame reset at bit 3.
    wait_ready("mrst");
    bus.start_i = 1'b1;
    bus.a_i = 6'h3F;
    bus.b_i = 6'h3F;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("mrst_bit3_valid", 32'(bus.valid_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outs("mrst_abort");
    chk("mrst_ready", 32'(bus.ready_o), 32'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done_o === 1'b1) vcount++;
      @(negedge clk);
    end
    chk("mrst_no_done", 32'(vcount), 32'd0);
    run_frame(vecs[2], "mrst_full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dual_serial_tx.md
Name: dual_serial_tx

Overview:
- Dual-lane parallel-to-serial transmitter: accepts two WIDTH-bit operand words in one handshake, shifts them out MSB-first, one bit per lane per clock.
- Source side of the two-lane serial operand interface consumed by the serial mod-4 checker, which samples in_1/in_2 on posedge.
- Replaces bench-side bit-banging tasks and serves as the on-chip stimulus source.

Parameters:
- WIDTH, 6, bits per word per lane; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  load request; accepted only when ready_o=1
- a_i  input  WIDTH  word for lane 1, sampled on accepted start
- b_i  input  WIDTH  word for lane 2, sampled on accepted start
- ready_o  output  1  high in IDLE; block can accept start_i
- out_1  output  1  lane-1 serial bit (drives checker in_1)
- out_2  output  1  lane-2 serial bit (drives checker in_2)
- valid_o  output  1  high while out_1/out_2 carry a data (or parity) bit
- last_o  output  1  high on the final bit of the frame
- done_o  output  1  one-cycle pulse after the frame completes

Behaviour:
- Reset is synchronous and active-high; single clock clk. While rst=1 at a posedge: state=IDLE, counter=0, shift registers=0, ready_o=1, out_1=out_2=0, valid_o=0, last_o=0, done_o=0.
- FSM states:
  - IDLE: ready_o=1, outputs 0. If start_i=1, latch a_i/b_i into the lane shift registers and go to SHIFT.
  - SHIFT: valid_o=1; out_1/out_2 = MSB of their shift register; counter increments and both registers shift left by one each cycle.
  - DONE: done_o=1 for one cycle, outputs 0, then return to IDLE.
- SHIFT exit: after the counter reaches WIDTH-1, the next state is DONE (or PARITY when PARITY_EN is defined).
- Latency: first bit (the MSB) appears one cycle after the accepting edge and is held for exactly one clock. Bit k (0 = MSB) appears in cycle k+1. last_o is asserted with bit WIDTH-1.
- Frame period: WIDTH+2 cycles start-to-ready, or WIDTH+3 with PARITY_EN.
- start_i outside IDLE is ignored; a_i and b_i are don't-care outside the accept cycle. Input changes mid-frame do not affect the frame in flight.
- Outputs are registered with no combinational path from inputs. out_1/out_2 are forced to 0 whenever valid_o=0.
- rst asserted mid-frame aborts the frame: at the next edge all outputs take reset values, with no done_o pulse and no partial parity.
- start_i held high continuously gives back-to-back frames separated by the DONE cycle plus the IDLE accept cycle.
- Counter wraps to 0 on frame exit and never exceeds WIDTH-1.

Optional Feature:
- Macro: DUAL_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state follows SHIFT for one cycle. out_1 = even parity (XOR) of the latched a word, out_2 = XOR of the latched b word, valid_o=1. last_o moves to the parity cycle; done_o follows it.
- Undefined: no PARITY state and no parity logic; the frame is exactly WIDTH bits.

Decomposition:
- Package dual_serial_pkg holds:
  - state encoding localparams ST_IDLE, ST_SHIFT, ST_PARITY, ST_DONE (2 bits);
  - default WIDTH constant;
  - a parity-function helper.
- Sub-module piso_lane (WIDTH-bit load/shift register with MSB out and running XOR) is instantiated once per lane. FSM and counter stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles with start_i=1 -> ready_o=1, valid_o=0, out_1=out_2=0, no frame starts.
- Single frame: a_i=6'b100100, b_i=6'b100010, pulse start_i -> over cycles 1..6, out_1=1,0,0,1,0,0 and out_2=1,0,0,0,1,0; last_o on cycle 6; done_o on cycle 7; ready_o on cycle 8.
- Busy ignore: start_i pulsed with a_i=6'h3F during SHIFT of the frame a_i=6'h00 -> lane 1 stays all zeros; no second frame is queued.
- Back-to-back: start_i held high with a_i=6'h2A then 6'h15 -> frames 101010 then 010101, separated by exactly 2 non-valid cycles.
- Mid-frame reset: rst=1 at bit 3 of a 6-bit frame -> next edge valid_o=0, out_1=out_2=0; done_o never pulses; the next start transmits a full 6 bits.
- Parity (macro defined): a_i=6'b100100, b_i=6'b100010 -> 7th valid bit out_1=0, out_2=0, last_o on that bit; with a_i=6'b100000 -> out_1 parity bit=1.
